// File: rtl/sram_1r1w_pkg.sv
// Shared definitions for the 1R1W masked SRAM: FSM states and default sizes.
// Used by sram_1r1w_masked_bypass and sram_lane_merge.
package sram_1r1w_pkg;
  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_ADDR_WIDTH  = 10;
  localparam int DEF_WMASK_WIDTH = 4;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_t;
endpackage

// File: rtl/sram_lane_merge.sv
// Per-lane word merge: lanes with a set mask bit take i_new, others keep i_old.
// Shared by the array write path and the same-edge read bypass.
module sram_lane_merge
  import sram_1r1w_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int WMASK_WIDTH = DEF_WMASK_WIDTH
) (
  input  logic [DATA_WIDTH-1:0]  i_old,
  input  logic [DATA_WIDTH-1:0]  i_new,
  input  logic [WMASK_WIDTH-1:0] i_mask,
  output logic [DATA_WIDTH-1:0]  o_merged
);
  localparam int LW = DATA_WIDTH / WMASK_WIDTH;

  // Start from the old word and overwrite enabled lanes.
  always_comb begin
    o_merged = i_old;
    for (int i = 0; i < WMASK_WIDTH; i++) begin
      if (i_mask[i]) begin
        o_merged[i*LW +: LW] = i_new[i*LW +: LW];
      end
    end
  end
endmodule

// File: rtl/sram_1r1w_masked_bypass.sv
// 1R1W SRAM with lane write mask, zero-fill sweep after reset, 1-cycle reads.
// Define SRAM_WR_BYPASS_EN to forward same-edge same-address write data to the read.
module sram_1r1w_masked_bypass
  import sram_1r1w_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int WMASK_WIDTH = DEF_WMASK_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   csb0,
  input  logic [ADDR_WIDTH-1:0]  addr0,
  input  logic [DATA_WIDTH-1:0]  din0,
  input  logic [WMASK_WIDTH-1:0] wmask0,
  input  logic                   csb1,
  input  logic [ADDR_WIDTH-1:0]  addr1,
  output logic [DATA_WIDTH-1:0]  dout1,
  output logic                   dout1_valid,
  output logic                   rw_collision,
  output logic                   ready
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  generate
    if (DATA_WIDTH % WMASK_WIDTH != 0) begin : g_bad_mask
      $error("DATA_WIDTH must be a multiple of WMASK_WIDTH");
    end
  endgenerate

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [ADDR_WIDTH-1:0] w_cnt_nxt;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_dout;
  logic                  r_valid;
  logic                  r_coll;
  logic [DATA_WIDTH-1:0] w_old;
  logic [DATA_WIDTH-1:0] w_merged;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic                  w_run;
  logic                  w_wr;
  logic                  w_rd;
  logic                  w_hit;

  assign w_run = (r_state == READY);
  assign w_wr  = w_run & ~csb0 & (|wmask0);
  assign w_rd  = w_run & ~csb1;
  assign w_hit = w_wr & w_rd & (addr0 == addr1);
  assign w_old = r_mem[addr0];

  sram_lane_merge #(
    .DATA_WIDTH  (DATA_WIDTH),
    .WMASK_WIDTH (WMASK_WIDTH)
  ) u_merge (
    .i_old    (w_old),
    .i_new    (din0),
    .i_mask   (wmask0),
    .o_merged (w_merged)
  );

`ifdef SRAM_WR_BYPASS_EN
  assign w_rd_data = w_hit ? w_merged : r_mem[addr1];
`else
  assign w_rd_data = r_mem[addr1];
`endif

  // State and sweep counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Sweep advances one address per cycle; READY is terminal.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      INIT: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == '1) begin
          w_state_nxt = READY;
        end
      end
      READY: begin
        w_cnt_nxt = r_cnt;
      end
    endcase
  end

  // Array: zero-fill while sweeping, masked user writes once ready.
  always_ff @(posedge clk) begin
    if (!w_run) begin
      r_mem[r_cnt] <= '0;
    end else if (w_wr) begin
      r_mem[addr0] <= w_merged;
    end
  end

  // Registered read result with valid and collision flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dout  <= '0;
      r_valid <= 1'b0;
      r_coll  <= 1'b0;
    end else begin
      r_valid <= w_rd;
      r_coll  <= w_hit;
      if (w_rd) begin
        r_dout <= w_rd_data;
      end
    end
  end

  assign dout1        = r_dout;
  assign dout1_valid  = r_valid;
  assign rw_collision = r_coll;
  assign ready        = w_run;
endmodule

// File: tb/tb_sram_1r1w_masked_bypass.sv
// Bench for sram_1r1w_masked_bypass (32-bit data, 16 words, 4 lanes).
// Expected collision data follows SRAM_WR_BYPASS_EN when it is defined.
module tb_sram_1r1w_masked_bypass;
  logic        clk;
  logic        rst;
  logic        csb0;
  logic [3:0]  addr0;
  logic [31:0] din0;
  logic [3:0]  wmask0;
  logic        csb1;
  logic [3:0]  addr1;
  logic [31:0] dout1;
  logic        dout1_valid;
  logic        rw_collision;
  logic        ready;

`ifdef SRAM_WR_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] model [16];
  logic [31:0] m_dout;

  typedef struct {
    logic        c0;
    logic [3:0]  a0;
    logic [31:0] d0;
    logic [3:0]  m0;
    logic        c1;
    logic [3:0]  a1;
    logic        ev;
    logic [31:0] ed;
    logic        ec;
  } vec_t;

  vec_t tbl[$];

  sram_1r1w_masked_bypass #(
    .DATA_WIDTH  (32),
    .ADDR_WIDTH  (4),
    .WMASK_WIDTH (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .csb0         (csb0),
    .addr0        (addr0),
    .din0         (din0),
    .wmask0       (wmask0),
    .csb1         (csb1),
    .addr1        (addr1),
    .dout1        (dout1),
    .dout1_valid  (dout1_valid),
    .rw_collision (rw_collision),
    .ready        (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic c0, input logic [3:0] a0,
                       input logic [31:0] d0, input logic [3:0] m0,
                       input logic c1, input logic [3:0] a1);
    csb0 = c0; addr0 = a0; din0 = d0; wmask0 = m0;
    csb1 = c1; addr1 = a1;
  endtask

  task automatic idle();
    drive(1'b1, 4'd0, 32'd0, 4'd0, 1'b1, 4'd0);
  endtask

  function automatic logic [31:0] lane_mix(input logic [31:0] o,
                                           input logic [31:0] n,
                                           input logic [3:0] m);
    logic [31:0] bm;
    bm = 32'd0;
    for (int i = 0; i < 4; i++)
      if (m[i]) bm = bm | (32'hFF << (8 * i));
    return (o & ~bm) | (n & bm);
  endfunction

  function automatic vec_t mk(input logic c0, input logic [3:0] a0,
                              input logic [31:0] d0, input logic [3:0] m0,
                              input logic c1, input logic [3:0] a1,
                              input logic ev, input logic [31:0] ed,
                              input logic ec);
    vec_t v;
    v.c0 = c0; v.a0 = a0; v.d0 = d0; v.m0 = m0;
    v.c1 = c1; v.a1 = a1; v.ev = ev; v.ed = ed; v.ec = ec;
    return v;
  endfunction

  // One cycle of reference behaviour while the array is ready.
  task automatic model_cycle(input logic c0, input logic [3:0] a0,
                             input logic [31:0] d0, input logic [3:0] m0,
                             input logic c1, input logic [3:0] a1,
                             output logic ev, output logic ec);
    logic        wr;
    logic [31:0] nw;
    wr = !c0 && (m0 != 4'd0);
    nw = lane_mix(model[a0], d0, m0);
    ev = !c1;
    ec = !c1 && wr && (a0 == a1);
    if (!c1) m_dout = (ec && BYP) ? nw : model[a1];
    if (wr) model[a0] = nw;
  endtask

  task automatic sweep(input int stop_at, output int n, output int vp);
    n = 0;
    vp = 0;
    while (!ready && n < 100 && n != stop_at) begin
      n++;
      step();
      if (dout1_valid) vp++;
    end
  endtask

  initial begin
    int          n;
    int          vp;
    logic        ev;
    logic        ec;
    logic [31:0] collx;
    logic        c0;
    logic        c1;
    logic [3:0]  a0;
    logic [3:0]  a1;
    logic [3:0]  m0;
    logic [31:0] d0;

    collx = BYP ? 32'hFFFFFFFF : 32'h12345678;
    for (int i = 0; i < 16; i++) model[i] = 32'd0;
    m_dout = 32'd0;

    idle();
    rst = 1'b1;
    #1;
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_dout", dout1, 32'd0);
    chk("rst_valid", {31'd0, dout1_valid}, 32'd0);
    chk("rst_coll", {31'd0, rw_collision}, 32'd0);
    step();
    step();

    // Sweep with requests held active; they must be ignored.
    drive(1'b0, 4'd2, 32'hDEADBEEF, 4'hF, 1'b0, 4'd2);
    rst = 1'b0;
    sweep(-1, n, vp);
    idle();
    chk("sweep_len", n, 32'd16);
    chk("init_valid_pulses", vp, 32'd0);
    chk("ready_up", {31'd0, ready}, 32'd1);

    for (int a = 0; a < 16; a++)
      tbl.push_back(mk(1, 0, 0, 0, 0, 4'(a), 1, 32'h0, 0));
    tbl.push_back(mk(0, 3, 32'hAABBCCDD, 4'hF, 1, 0, 0, 32'h0, 0));
    tbl.push_back(mk(0, 3, 32'h11223344, 4'h5, 1, 0, 0, 32'h0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 3, 1, 32'hAA22CC44, 0));
    tbl.push_back(mk(0, 5, 32'h12345678, 4'hF, 0, 3, 1, 32'hAA22CC44, 0));
    tbl.push_back(mk(0, 5, 32'hFFFFFFFF, 4'hF, 0, 5, 1, collx, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 5, 1, 32'hFFFFFFFF, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, 32'hFFFFFFFF, 0));
    tbl.push_back(mk(0, 5, 32'h0, 4'h0, 1, 0, 0, 32'hFFFFFFFF, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 5, 1, 32'hFFFFFFFF, 0));
    tbl.push_back(mk(0, 7, 32'h0BADF00D, 4'hA, 0, 3, 1, 32'hAA22CC44, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 7, 1, 32'h0B00F000, 0));

    foreach (tbl[i]) begin
      drive(tbl[i].c0, tbl[i].a0, tbl[i].d0, tbl[i].m0,
            tbl[i].c1, tbl[i].a1);
      model_cycle(tbl[i].c0, tbl[i].a0, tbl[i].d0, tbl[i].m0,
                  tbl[i].c1, tbl[i].a1, ev, ec);
      step();
      chk($sformatf("tbl%0d_valid", i), {31'd0, dout1_valid},
          {31'd0, tbl[i].ev});
      chk($sformatf("tbl%0d_dout", i), dout1, tbl[i].ed);
      chk($sformatf("tbl%0d_coll", i), {31'd0, rw_collision},
          {31'd0, tbl[i].ec});
    end
    idle();

    // Random traffic against the reference array.
    for (int k = 0; k < 400; k++) begin
      c0 = ($urandom_range(0, 3) != 0) ? 1'b0 : 1'b1;
      c1 = ($urandom_range(0, 3) != 0) ? 1'b0 : 1'b1;
      a0 = 4'($urandom_range(0, 15));
      a1 = ($urandom_range(0, 3) == 0) ? a0 : 4'($urandom_range(0, 15));
      m0 = 4'($urandom_range(1, 15));
      d0 = $urandom;
      drive(c0, a0, d0, m0, c1, a1);
      model_cycle(c0, a0, d0, m0, c1, a1, ev, ec);
      step();
      chk($sformatf("rnd%0d_valid", k), {31'd0, dout1_valid}, {31'd0, ev});
      chk($sformatf("rnd%0d_dout", k), dout1, m_dout);
      chk($sformatf("rnd%0d_coll", k), {31'd0, rw_collision}, {31'd0, ec});
    end
    idle();

    // Reset mid-operation with a valid read result showing.
    drive(1'b0, 4'd1, 32'hCAFEF00D, 4'hF, 1'b1, 4'd0);
    step();
    drive(1'b1, 4'd0, 32'd0, 4'd0, 1'b0, 4'd1);
    step();
    idle();
    chk("pre_rst_dout", dout1, 32'hCAFEF00D);
    chk("pre_rst_valid", {31'd0, dout1_valid}, 32'd1);
    rst = 1'b1;
    #1;
    chk("op_rst_ready", {31'd0, ready}, 32'd0);
    chk("op_rst_dout", dout1, 32'd0);
    chk("op_rst_valid", {31'd0, dout1_valid}, 32'd0);
    step();
    step();
    rst = 1'b0;
    sweep(-1, n, vp);
    chk("op_rst_sweep_len", n, 32'd16);

    // Reset again when the sweep reaches address 7.
    rst = 1'b1;
    step();
    rst = 1'b0;
    sweep(7, n, vp);
    chk("mid_sweep_steps", n, 32'd7);
    chk("mid_sweep_not_ready", {31'd0, ready}, 32'd0);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", {31'd0, ready}, 32'd0);
    chk("mid_rst_dout", dout1, 32'd0);
    step();
    step();
    rst = 1'b0;
    sweep(-1, n, vp);
    chk("mid_rst_sweep_len", n, 32'd16);

    drive(1'b1, 4'd0, 32'd0, 4'd0, 1'b0, 4'd1);
    step();
    idle();
    chk("post_sweep_valid", {31'd0, dout1_valid}, 32'd1);
    chk("post_sweep_dout", dout1, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sram_1r1w_masked_bypass.md
SRAM_1R1W_MASKED_BYPASS -- requirements
Module: sram_1r1w_masked_bypass

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: data word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10: address width; depth = 2**ADDR_WIDTH.
REQ-003 SHALL have parameter WMASK_WIDTH, default 4: number of write lanes; lane width = DATA_WIDTH/WMASK_WIDTH.
REQ-004 clk  input  1  single clock for both ports, rising-edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 csb0  input  1  write port chip select, active low.
REQ-007 addr0  input  ADDR_WIDTH  write address.
REQ-008 din0  input  DATA_WIDTH  write data.
REQ-009 wmask0  input  WMASK_WIDTH  per-lane write enable, bit i covers din0 lane i.
REQ-010 csb1  input  1  read port chip select, active low.
REQ-011 addr1  input  ADDR_WIDTH  read address.
REQ-012 dout1  output  DATA_WIDTH  registered read data.
REQ-013 dout1_valid  output  1  high for one cycle when dout1 carries a fresh read result.
REQ-014 rw_collision  output  1  high with dout1_valid when that read hit the address written on the same edge.
REQ-015 ready  output  1  high when the array is initialised and accepting requests.

Function
REQ-016 State machine SHALL have states INIT and READY. It SHALL move from INIT to READY on the cycle after the sweep writes address 2**ADDR_WIDTH-1. READY SHALL be terminal until reset.
REQ-017 In INIT the block SHALL write all-zero words to consecutive addresses 0..2**ADDR_WIDTH-1, one per cycle. ready SHALL be 0. csb0/csb1 requests SHALL be ignored, with no array change and no dout1_valid.
REQ-018 In READY, ready SHALL be 1. All port inputs SHALL be sampled on each rising edge.
REQ-019 A write sampled at edge E with csb0=0 SHALL update only the lanes whose wmask0 bit is 1 at addr0, committed by edge E+1. Lanes with a 0 mask bit SHALL retain their old contents.
REQ-020 csb0=0 with wmask0 all zero SHALL be a no-op.
REQ-021 A read sampled at edge E with csb1=0 SHALL drive dout1 and dout1_valid=1 from edge E+1, so read latency is one cycle.
REQ-022 Back-to-back reads SHALL be supported every cycle.
REQ-023 When no read is sampled, dout1 SHALL hold its last value and dout1_valid SHALL be 0.
REQ-024 A read sampled one or more edges after a write to the same address SHALL return the post-write contents.
REQ-025 When a read and a write to the same address are sampled on the same edge, rw_collision SHALL be 1 alongside dout1_valid. The returned data is given by REQ-030/031.
REQ-026 Different-address same-edge read and write SHALL both complete with rw_collision=0.

Reset
REQ-027 On rst assertion, without waiting for a clock edge: state=INIT, sweep counter=0, ready=0, dout1=0, dout1_valid=0, rw_collision=0.
REQ-028 Reset asserted mid-sweep or mid-operation SHALL restart the sweep from address 0 after deassertion. Any in-flight read result SHALL be discarded.
REQ-029 Array contents SHALL not be reset directly; only the sweep clears them.

Configuration
REQ-030 With macro SRAM_WR_BYPASS_EN defined, a same-edge same-address read SHALL return the lane-merged new word: din0 lanes where wmask0=1, old data elsewhere.
REQ-031 Without SRAM_WR_BYPASS_EN, that read SHALL return the old contents. rw_collision behaviour SHALL be identical in both builds.

Structure
REQ-032 Package sram_1r1w_pkg SHALL hold the state enum (INIT, READY) and the default parameter constants.
REQ-033 Elaboration SHALL fail if DATA_WIDTH is not divisible by WMASK_WIDTH.
REQ-034 Lane-merge logic, shared by write commit and bypass, SHALL be a sub-module sram_lane_merge: inputs old, new, mask; output merged word.

Verification (DATA_WIDTH=32, ADDR_WIDTH=4, WMASK_WIDTH=4)
REQ-035 Release rst -> ready=0 for exactly 16 cycles, then ready=1. Reading addr 0..15 then returns 0x00000000 each, with dout1_valid one cycle after each request.
REQ-036 Write 0xAABBCCDD mask 0xF to addr 3, then write 0x11223344 mask 0x5 to addr 3, then read addr 3 -> dout1=0xAA22CC44.
REQ-037 With addr 5 holding 0x12345678, issue a same-edge write 0xFFFFFFFF mask 0xF and read, both to addr 5 -> rw_collision=1; dout1=0xFFFFFFFF with SRAM_WR_BYPASS_EN, 0x12345678 without. A following read returns 0xFFFFFFFF in both builds.
REQ-038 Assert rst at sweep address 7 and hold for 2 cycles -> ready=0 immediately, dout1=0. After release, ready rises exactly 16 cycles later.
REQ-039 During INIT, issue a write of 0xDEADBEEF to addr 2 -> no effect: a read of addr 2 after ready returns 0x00000000, and no dout1_valid pulse occurs during INIT.
